alu_control_pipe: RTL
=====================

# alu_control_pipe

Parametrised ALU control unit for the multicycle RISC-V core, decoding `aluOp`/`funct3`/`funct7b5` into the 4-bit ALU operation code consumed by the ALU. It extends the fixed-phase ALU control with the full RV32I integer op set, illegal-encoding detection, a configurable decode pipeline, and two sampling modes:

- **Handshake mode:** valid/ready.
- **Phase mode:** sampling on a programmable phase of a free-running counter, matching the control FSM step period.

## Interface

Parameters:
- `CTRL_W`, default 4: width of `saidaAluControl`; must be ≥ 4; codes are zero-extended.
- `LATENCY`, default 1: decode pipeline stages, legal range 1..4.
- `PERIOD`, default 0: 0 selects handshake mode; N > 0 selects phase mode with a counter wrapping 0..N-1.
- `SAMPLE_PHASE`, default 5: counter value at which inputs are sampled in phase mode; must be < `PERIOD`.
- `CNT_W`, default 8: width of the illegal-encoding counter.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `aluOp` in 2: 00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- `funct3` in 3: instruction funct3.
- `funct7b5` in 1: instruction bit 30.
- `in_valid` in 1: input valid; handshake mode only.
- `in_ready` out 1: unit accepts inputs this cycle.
- `out_ready` in 1: downstream accepts the result; handshake mode only.
- `saidaAluControl` out `CTRL_W`: registered ALU operation code.
- `out_valid` out 1: `saidaAluControl` holds a new result.
- `illegal` out 1: the result currently presented came from an illegal encoding.
- `clear_count` in 1: synchronous clear of `illegal_count`.
- `illegal_count` out `CNT_W`: saturating count of accepted illegal encodings.

## Operation

**ALU op codes:**
- AND = 0000, OR = 0001, ADD = 0010, XOR = 0011
- SLL = 0100, SRL = 0101, SUB = 0110, SRA = 0111
- SLT = 1000, SLTU = 1001

**Decode by `aluOp`:**
- **00:** ADD, regardless of `funct3`/`funct7b5`.
- **01 (branch):**
  - `funct3` 000/001 → SUB
  - 100/101 → SLT
  - 110/111 → SLTU
  - 010/011 → illegal
- **10 (R-type):**
  - 000 → ADD if `funct7b5` = 0, SUB if 1
  - 001 → SLL
  - 010 → SLT
  - 011 → SLTU
  - 100 → XOR
  - 101 → SRL if `funct7b5` = 0, SRA if 1
  - 110 → OR
  - 111 → AND
  - `funct7b5` = 1 with `funct3` other than 000/101 → illegal
- **11 (I-type):** same as 10, except:
  - 000 → always ADD (`funct7b5` ignored)
  - 001 with `funct7b5` = 1 → illegal
- **Illegal encoding:** code ADD, `illegal` = 1 attached to that result.

**Handshake mode (`PERIOD` = 0):**
- Global advance signal: `adv = !out_valid | out_ready`.
- `in_ready = adv`.
- Accept on `in_valid & in_ready`; the accepted tuple enters stage 1 with a valid bit.
- All stages shift only when `adv` = 1; when `adv` = 0 the whole pipeline holds.

**Phase mode (`PERIOD` > 0):**
- `phase` counter increments every cycle and wraps `PERIOD-1` → 0.
- `in_ready = (phase == SAMPLE_PHASE)`.
- `in_valid` and `out_ready` are ignored; inputs are accepted unconditionally at `SAMPLE_PHASE`.
- The pipeline always advances.

**Output:**
- `saidaAluControl` and `illegal` update only when a valid result leaves the last stage.
- Otherwise they hold their last value; `out_valid` drops once the result is consumed.
- In phase mode `out_valid` is a 1-cycle pulse.

**`illegal_count`:**
- Increments when an illegal encoding is accepted at input (not when it exits the pipeline).
- Saturates at all-ones.
- `clear_count` zeroes it; if clear and increment occur in the same cycle, clear wins.

## Timing

- **Reset (`reset` = 0), asynchronous:**
  - `saidaAluControl` = 0, `out_valid` = 0, `illegal` = 0, `illegal_count` = 0.
  - All stage valid bits = 0, `phase` = 0.
  - `in_ready` = 1 in handshake mode; in phase mode it is 1 only if `SAMPLE_PHASE` = 0.
- Reset asserted mid-pipeline discards all in-flight results; no `out_valid` follows release.
- **Latency:** a result accepted at edge T drives `saidaAluControl`/`out_valid` after edge T+`LATENCY` (absent stalls).
- **Throughput:**
  - Handshake mode: 1 per cycle while `out_ready` = 1.
  - Phase mode: 1 per `PERIOD` cycles.
- **Stall:**
  - `out_valid` = 1 with `out_ready` = 0 holds every stage and output.
  - `in_ready` = 0 the same cycle; no result is dropped or duplicated.
- A simultaneous output consume and input accept is legal and must not create a bubble.
- **Phase mode:** first sample at the edge where `phase` = `SAMPLE_PHASE` (the `SAMPLE_PHASE`+1-th edge after reset release). Phase wrap is exact with no skipped value.

## Test plan

- **Handshake, `LATENCY` = 1:** `aluOp` = 10, `funct3` = 000, `funct7b5` = 1, `in_valid` = 1 → one edge later `saidaAluControl` = 0110, `out_valid` = 1, `illegal` = 0.
- **Full decode sweep:** all 64 `aluOp`/`funct3`/`funct7b5` combinations → codes per the table above. `aluOp` = 01 with `funct3` = 010 → 0010 with `illegal` = 1, and `illegal_count` increments to 1.
- **Backpressure, `LATENCY` = 3:**
  - Stream: AND, OR, XOR, SRA.
  - Hold `out_ready` = 0 for 4 cycles after the first `out_valid`.
  - Required: `in_ready` = 0 during the hold; outputs appear in order 0000, 0001, 0011, 0111 with none lost.
- **Phase mode, `PERIOD` = 10, `SAMPLE_PHASE` = 5:**
  - Inputs R-type `funct3` = 001 held constant.
  - `in_ready` pulses on the 6th, 16th, 26th edges after reset release.
  - Required: `out_valid` pulses `LATENCY` edges later with `saidaAluControl` = 0100.
- **Counter:** 300 illegal encodings with `CNT_W` = 8 → `illegal_count` saturates at 255. `clear_count` asserted together with an illegal accept → count = 0.
- **Reset mid-operation:** assert `reset` = 0 asynchronously with 2 results in flight → outputs are 0 immediately without waiting for a clock edge. No `out_valid` appears after release until a new accept.

Source files
------------

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: RV32I ALU control decode behind a configurable register pipeline,
// sampled either by valid/ready handshake (PERIOD == 0) or on a fixed counter phase.
module alu_control_pipe #(
    parameter int CTRL_W       = 4,
    parameter int LATENCY      = 1,
    parameter int PERIOD       = 0,
    parameter int SAMPLE_PHASE = 5,
    parameter int CNT_W        = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        aluOp,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] saidaAluControl,
    output logic              out_valid,
    output logic              illegal,
    input  logic              clear_count,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [3:0]       w_code;
    logic             w_illegal;
    logic             w_adv;
    logic             w_accept;

    logic [3:0]       r_stCode  [LATENCY];
    logic             r_stIll   [LATENCY];
    logic             r_stValid [LATENCY];
    logic [3:0]       r_outCode;
    logic             r_outIll;
    logic             r_outValid;
    logic [CNT_W-1:0] r_illCount;

    always_comb begin
        w_code    = OP_ADD;
        w_illegal = 1'b0;
        case (aluOp)
            2'b00: w_code = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: w_code = OP_SUB;
                    3'b100, 3'b101: w_code = OP_SLT;
                    3'b110, 3'b111: w_code = OP_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000:  w_code = (funct7b5 && !aluOp[0]) ? OP_SUB : OP_ADD;
                    3'b001:  w_code = OP_SLL;
                    3'b010:  w_code = OP_SLT;
                    3'b011:  w_code = OP_SLTU;
                    3'b100:  w_code = OP_XOR;
                    3'b101:  w_code = funct7b5 ? OP_SRA : OP_SRL;
                    3'b110:  w_code = OP_OR;
                    default: w_code = OP_AND;
                endcase
                // funct7b5 only picks a variant for 000/101; anywhere else it is a bad encoding
                if (funct7b5 && funct3 != 3'b000 && funct3 != 3'b101) begin
                    w_illegal = 1'b1;
                    w_code    = OP_ADD;
                end
            end
        endcase
    end

    generate
        if (PERIOD == 0) begin : g_handshake
            assign w_adv    = !r_outValid | out_ready;
            assign in_ready = w_adv;
            assign w_accept = in_valid & w_adv;
        end else begin : g_phase
            localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            logic [PH_W-1:0] r_phase;
            logic            w_unused;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset)                            r_phase <= '0;
                else if (r_phase == PH_W'(PERIOD - 1)) r_phase <= '0;
                else                                   r_phase <= r_phase + 1'b1;
            end

            assign w_unused = in_valid ^ out_ready;
            assign w_adv    = 1'b1;
            assign in_ready = (r_phase == PH_W'(SAMPLE_PHASE));
            assign w_accept = in_ready;
        end
    endgenerate

    // Every stage moves together on w_adv, so a stall freezes the pipe without gaps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stCode[i]  <= '0;
                r_stIll[i]   <= 1'b0;
                r_stValid[i] <= 1'b0;
            end
        end else if (w_adv) begin
            r_stCode[0]  <= w_code;
            r_stIll[0]   <= w_illegal;
            r_stValid[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_stCode[i]  <= r_stCode[i-1];
                r_stIll[i]   <= r_stIll[i-1];
                r_stValid[i] <= r_stValid[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outCode  <= '0;
            r_outIll   <= 1'b0;
            r_outValid <= 1'b0;
        end else if (w_adv) begin
            r_outValid <= r_stValid[LATENCY-1];
            if (r_stValid[LATENCY-1]) begin
                r_outCode <= r_stCode[LATENCY-1];
                r_outIll  <= r_stIll[LATENCY-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                        r_illCount <= '0;
        else if (clear_count)                              r_illCount <= '0;
        else if (w_accept && w_illegal && r_illCount != '1) r_illCount <= r_illCount + 1'b1;
    end

    assign saidaAluControl = CTRL_W'(r_outCode);
    assign out_valid       = r_outValid;
    assign illegal         = r_outIll;
    assign illegal_count   = r_illCount;

endmodule
